// File: rtl/div_radix2_pkg.sv
// Shared definitions for the radix-2 divider: state encoding, default width, counter sizing.
// No logic here; latency and backpressure are defined by the modules that import it.
// Counter width is clog2(width)+1 so the iteration count never wraps.
package div_radix2_pkg;

    localparam int DIV_W_DEFAULT = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

    function automatic int div_cnt_w(input int w);
        return $clog2(w) + 1;
    endfunction

    localparam int CNT_W_DEFAULT = div_cnt_w(DIV_W_DEFAULT);

endpackage

// File: rtl/div_step.sv
// One restoring radix-2 iteration: shift in a dividend bit, trial-subtract, pick quotient bit.
// Purely combinational, zero latency.
// No flow control; the caller decides when to register the result.
module div_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] rem_in,
    input  logic         dividend_bit,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_out,
    output logic         q_bit
);

    logic [W:0] shifted;
    logic [W:0] diff;

    // rem_in < divisor, so shifted < 2*divisor: the top bit of a W+1 wide
    // difference is exactly the borrow.
    assign shifted = {rem_in, dividend_bit};
    assign diff    = shifted - {1'b0, divisor};
    assign q_bit   = ~diff[W];
    assign rem_out = q_bit ? diff[W-1:0] : shifted[W-1:0];

endmodule

// File: rtl/div_radix2.sv
// Iterative signed/unsigned divider for the E stage: hi = remainder, lo = quotient.
// Latency: DIV_W+1 stall cycles from start, result registered on entry to DONE.
// Stalls the pipeline via div_stall; holds the result in DONE while hold is high.
module div_radix2
    import div_radix2_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEFAULT
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             signed_div,
    input  logic [DIV_W-1:0] a,
    input  logic [DIV_W-1:0] b,
    input  logic             flush,
    input  logic             hold,
    output logic             div_stall,
    output logic             result_valid,
    output logic [DIV_W-1:0] hi,
    output logic [DIV_W-1:0] lo
);

    localparam int               CNT_W    = div_cnt_w(DIV_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    div_state_t       state;
    div_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;

    logic [DIV_W-1:0] rem_q;
    logic [DIV_W-1:0] quo_q;
    logic [DIV_W-1:0] dvs_q;
    logic             a_neg_q;
    logic             b_neg_q;
    logic             dvs_zero_q;

    logic             accept;
    logic             step_en;
    logic             last_step;

    logic             a_neg;
    logic             b_neg;
    logic [DIV_W-1:0] a_mag;
    logic [DIV_W-1:0] b_mag;

    logic [DIV_W-1:0] step_rem;
    logic             step_q;
    logic [DIV_W-1:0] quo_fin;
    logic [DIV_W-1:0] rem_fin;
    logic [DIV_W-1:0] lo_fin;
    logic [DIV_W-1:0] hi_fin;

    assign a_neg = signed_div & a[DIV_W-1];
    assign b_neg = signed_div & b[DIV_W-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    always_comb begin
        state_nxt    = state;
        div_stall    = 1'b0;
        result_valid = 1'b0;
        accept       = 1'b0;
        step_en      = 1'b0;
        last_step    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !flush) begin
                    accept    = 1'b1;
                    div_stall = 1'b1;
                    state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (flush) begin
                    state_nxt = ST_IDLE;
                end else begin
                    div_stall = 1'b1;
                    step_en   = 1'b1;
                    if (cnt == LAST_CNT) begin
                        last_step = 1'b1;
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                // A start seen here belongs to the instruction just completed.
                result_valid = 1'b1;
                if (flush || !hold) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    div_step #(
        .W(DIV_W)
    ) u_step (
        .rem_in      (rem_q),
        .dividend_bit(quo_q[DIV_W-1]),
        .divisor     (dvs_q),
        .rem_out     (step_rem),
        .q_bit       (step_q)
    );

    // Divide-by-zero keeps the raw all-ones quotient; the remainder path
    // naturally restores the original dividend.
    assign quo_fin = {quo_q[DIV_W-2:0], step_q};
    assign rem_fin = step_rem;
    assign lo_fin  = ((a_neg_q ^ b_neg_q) && !dvs_zero_q) ? -quo_fin : quo_fin;
    assign hi_fin  = a_neg_q ? -rem_fin : rem_fin;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt        <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            a_neg_q    <= 1'b0;
            b_neg_q    <= 1'b0;
            dvs_zero_q <= 1'b0;
            hi         <= '0;
            lo         <= '0;
        end else begin
            if (accept) begin
                cnt        <= '0;
                rem_q      <= '0;
                quo_q      <= a_mag;
                dvs_q      <= b_mag;
                a_neg_q    <= a_neg;
                b_neg_q    <= b_neg;
                dvs_zero_q <= (b == '0);
            end else if (step_en) begin
                cnt   <= cnt + CNT_ONE;
                rem_q <= step_rem;
                quo_q <= quo_fin;
            end
            if (last_step) begin
                hi <= hi_fin;
                lo <= lo_fin;
            end
        end
    end

endmodule
